// File: rtl/eight_point_ifft.sv
// eight_point_ifft: streaming 8-point inverse DFT, radix-2 DIT, one butterfly per cycle, output scaled by 1/8.
// Ports: CLK/RST_N (sync, active-low); in_valid/in_ready/in_real/in_imag frequency samples X[k];
// out_valid/out_ready/out_real/out_imag/out_index time samples x[n] in natural order; busy in COMPUTE/DRAIN.
// Optional macro IFFT_SIGNMAG_EN: sign-magnitude sample format on both input and output.
module eight_point_ifft #(
  parameter int WIDTH = 16
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_real,
  input  logic [WIDTH-1:0]        in_imag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_real,
  output logic [WIDTH-1:0]        out_imag,
  output logic [2:0]              out_index,
  output logic                    busy
);
  localparam int XW = WIDTH + 1;
  typedef enum logic [1:0] {LOAD, COMPUTE, DRAIN} state_t;
  state_t state_q, state_d;
  logic [2:0] load_cnt_q, load_cnt_d;
  logic [1:0] stage_q, stage_d;
  logic [1:0] bf_q, bf_d;
  logic signed [WIDTH-1:0] mem_r_q [8];
  logic signed [WIDTH-1:0] mem_i_q [8];
  logic signed [WIDTH-1:0] mem_r_d [8];
  logic signed [WIDTH-1:0] mem_i_d [8];
  logic out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_real_q, out_real_d, out_imag_q, out_imag_d;
  logic [2:0] out_index_q, out_index_d;
  logic [2:0] ia, ib;
  logic [1:0] tw;
  logic signed [XW-1:0] ar, ai, br, bi, bsub, badd, wr, wi, sum_r, sum_i, dif_r, dif_i;

  // c = 0.70703125 as a shift-add chain; each term truncates toward -inf
  function automatic logic signed [XW-1:0] cmul(input logic signed [XW-1:0] x);
    return (x >>> 1) + (x >>> 2) - (x >>> 4) + (x >>> 5) - (x >>> 6) + (x >>> 7) - (x >>> 8);
  endfunction

  function automatic logic signed [WIDTH-1:0] to_tc(input logic [WIDTH-1:0] x);
`ifdef IFFT_SIGNMAG_EN
    logic [WIDTH-1:0] mag;
    mag = {1'b0, x[WIDTH-2:0]};
    return $signed(x[WIDTH-1] ? -mag : mag);
`else
    return $signed(x);
`endif
  endfunction

  function automatic logic [WIDTH-1:0] to_out(input logic signed [WIDTH-1:0] x);
`ifdef IFFT_SIGNMAG_EN
    logic [WIDTH-1:0] neg;
    neg = -x;
    // the most negative value has no magnitude representation, so it saturates
    return !x[WIDTH-1] ? x : (neg[WIDTH-1] ? '1 : {1'b1, neg[WIDTH-2:0]});
`else
    return x;
`endif
  endfunction

  // butterfly addressing for bit-reversed-input DIT: span = 1 << stage
  always_comb begin
    ia = stage_q == 2'd0 ? {bf_q, 1'b0} : stage_q == 2'd1 ? {bf_q[1], 1'b0, bf_q[0]} : {1'b0, bf_q};
    ib = stage_q == 2'd0 ? ia | 3'd1 : stage_q == 2'd1 ? ia | 3'd2 : ia | 3'd4;
    tw = stage_q == 2'd0 ? 2'd0 : stage_q == 2'd1 ? {bf_q[0], 1'b0} : bf_q;
    ar = mem_r_q[ia];
    ai = mem_i_q[ia];
    br = mem_r_q[ib];
    bi = mem_i_q[ib];
    bsub = br - bi;
    badd = br + bi;
    wr = tw == 2'd0 ? br : tw == 2'd1 ? cmul(bsub) : tw == 2'd2 ? -bi : -cmul(badd);
    wi = tw == 2'd0 ? bi : tw == 2'd1 ? cmul(badd) : tw == 2'd2 ? br : cmul(bsub);
    sum_r = ar + wr;
    sum_i = ai + wi;
    dif_r = ar - wr;
    dif_i = ai - wi;
  end

  always_comb begin
    state_d = state_q;
    load_cnt_d = load_cnt_q;
    stage_d = stage_q;
    bf_d = bf_q;
    mem_r_d = mem_r_q;
    mem_i_d = mem_i_q;
    out_valid_d = out_valid_q;
    out_real_d = out_real_q;
    out_imag_d = out_imag_q;
    out_index_d = out_index_q;
    case (state_q)
      LOAD: if (in_valid) begin
        mem_r_d[{load_cnt_q[0], load_cnt_q[1], load_cnt_q[2]}] = to_tc(in_real);
        mem_i_d[{load_cnt_q[0], load_cnt_q[1], load_cnt_q[2]}] = to_tc(in_imag);
        load_cnt_d = load_cnt_q + 3'd1;
        state_d = load_cnt_q == 3'd7 ? COMPUTE : LOAD;
      end
      COMPUTE: begin
        mem_r_d[ia] = sum_r[WIDTH:1];
        mem_i_d[ia] = sum_i[WIDTH:1];
        mem_r_d[ib] = dif_r[WIDTH:1];
        mem_i_d[ib] = dif_i[WIDTH:1];
        bf_d = bf_q + 2'd1;
        stage_d = bf_q == 2'd3 ? (stage_q == 2'd2 ? 2'd0 : stage_q + 2'd1) : stage_q;
        state_d = bf_q == 2'd3 && stage_q == 2'd2 ? DRAIN : COMPUTE;
      end
      default: if (!out_valid_q) begin
        out_valid_d = 1'b1;
        out_real_d = to_out(mem_r_q[out_index_q]);
        out_imag_d = to_out(mem_i_q[out_index_q]);
      end else if (out_ready) begin
        out_valid_d = out_index_q != 3'd7;
        out_index_d = out_index_q + 3'd1;
        out_real_d = to_out(mem_r_q[out_index_q + 3'd1]);
        out_imag_d = to_out(mem_i_q[out_index_q + 3'd1]);
        state_d = out_index_q == 3'd7 ? LOAD : DRAIN;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= LOAD;
      load_cnt_q <= '0;
      stage_q <= '0;
      bf_q <= '0;
      mem_r_q <= '{default: '0};
      mem_i_q <= '{default: '0};
      out_valid_q <= 1'b0;
      out_real_q <= '0;
      out_imag_q <= '0;
      out_index_q <= '0;
    end else begin
      state_q <= state_d;
      load_cnt_q <= load_cnt_d;
      stage_q <= stage_d;
      bf_q <= bf_d;
      mem_r_q <= mem_r_d;
      mem_i_q <= mem_i_d;
      out_valid_q <= out_valid_d;
      out_real_q <= out_real_d;
      out_imag_q <= out_imag_d;
      out_index_q <= out_index_d;
    end
  end

  assign in_ready = state_q == LOAD;
  assign busy = state_q != LOAD;
  assign out_valid = out_valid_q;
  assign out_real = out_real_q;
  assign out_imag = out_imag_q;
  assign out_index = out_index_q;
endmodule

// File: tb/tb_eight_point_ifft.sv
// tb_eight_point_ifft: directed self-checking bench for eight_point_ifft.
module tb_eight_point_ifft;
  logic CLK = 0, RST_N = 0, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid, busy;
  logic signed [15:0] in_real = 0, in_imag = 0, out_real, out_imag;
  logic [2:0] out_index;
  int tests = 0, fails = 0;
  int xr [8], xi [8], er [8], ei [8];

  eight_point_ifft #(.WIDTH(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(in_ready),
    .in_real(in_real), .in_imag(in_imag), .out_valid(out_valid), .out_ready(out_ready),
    .out_real(out_real), .out_imag(out_imag), .out_index(out_index), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input int got, input int exp, input int tol);
    tests++;
    assert ((got - exp) <= tol && (exp - got) <= tol) else begin
      fails++;
      $error("FAIL %s observed %0d expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_in(input int v0, input int vr);
    for (int k = 0; k < 8; k++) begin
      xr[k] = vr;
      xi[k] = 0;
    end
    xr[0] = v0;
  endtask

  task automatic set_exp(input int v);
    for (int k = 0; k < 8; k++) begin
      er[k] = v;
      ei[k] = 0;
    end
  endtask

  task automatic send();
    for (int k = 0; k < 8; k++) begin
      in_valid = 1;
      in_real = 16'(xr[k]);
      in_imag = 16'(xi[k]);
      tick();
    end
    in_valid = 0;
    chk("in_ready_compute", int'(in_ready), 0);
    chk("busy_compute", int'(busy), 1);
  endtask

  task automatic wait_valid();
    int c = 0;
    while (!out_valid && c < 60) begin
      tick();
      c++;
    end
    chk("out_valid_timeout", int'(out_valid), 1);
  endtask

  task automatic drain(input int tol, input bit bp);
    int hr, hi;
    for (int n = 0; n < 8; n++) begin
      wait_valid();
      chk("out_index", int'(out_index), n);
      chk_tol($sformatf("re[%0d]", n), int'(out_real), er[n], tol);
      chk_tol($sformatf("im[%0d]", n), int'(out_imag), ei[n], tol);
      if (bp && n == 3) begin
        hr = int'(out_real);
        hi = int'(out_imag);
        out_ready = 0;
        for (int c = 0; c < 5; c++) begin
          in_valid = (c == 2);
          in_real = 16'sd1234;
          tick();
        end
        in_valid = 0;
        chk("bp_valid", int'(out_valid), 1);
        chk("bp_index", int'(out_index), 3);
        chk("bp_real", int'(out_real), hr);
        chk("bp_imag", int'(out_imag), hi);
        chk("bp_in_ready", int'(in_ready), 0);
        out_ready = 1;
      end
      tick();
    end
    chk("in_ready_after", int'(in_ready), 1);
    chk("out_valid_after", int'(out_valid), 0);
  endtask

  initial begin
    tick();
    tick();
    RST_N = 1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_real", int'(out_real), 0);
    chk("rst_out_imag", int'(out_imag), 0);
    chk("rst_out_index", int'(out_index), 0);

    // impulse with latency measurement: out_valid 13 edges after the 8th accepted beat
    set_in(800, 0);
    set_exp(100);
    send();
    begin
      int c = 1;
      tick();
      while (!out_valid && c < 40) begin
        tick();
        c++;
      end
      chk("latency", c, 13);
    end
    drain(0, 0);

    // single tone at bin 1
    set_in(0, 0);
    xr[1] = 800;
    er = '{100, 70, 0, -70, -100, -70, 0, 70};
    ei = '{0, 70, 100, 70, 0, -70, -100, -70};
    send();
    drain(2, 0);

    // flat spectrum
    set_in(800, 800);
    set_exp(0);
    er[0] = 800;
    send();
    drain(0, 0);

    // negative impulse with backpressure at index 3 and stray in_valid in DRAIN
    set_in(-800, 0);
    set_exp(-100);
    send();
    drain(0, 1);

    // next frame must be unaffected by the stray in_valid
    set_in(800, 0);
    set_exp(100);
    send();
    drain(0, 0);

    // reset at COMPUTE cycle 6
    send();
    for (int c = 0; c < 5; c++) tick();
    RST_N = 0;
    tick();
    RST_N = 1;
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    send();
    drain(0, 0);

`ifdef IFFT_SIGNMAG_EN
    for (int f = 0; f < 2; f++) begin
      set_in('h8320, f == 0 ? 'h0000 : 'h8000);
      send();
      for (int n = 0; n < 8; n++) begin
        wait_valid();
        chk("sm_index", int'(out_index), n);
        chk("sm_real", int'($unsigned(out_real)), 'h8064);
        chk("sm_imag", int'($unsigned(out_imag)), 'h0000);
        tick();
      end
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
